// File: rtl/seg_deshift_rx.sv
// seg_deshift_rx
// Receive side of the serial seven-segment display link. The shift clock and
// every segment lane are oversampled with the system clock, one byte per lane
// is reassembled MSB first ({dp,g,f,e,d,c,b,a}), and each byte is decoded
// back to a BCD digit with a legality flag. A partial frame that stalls for
// TIMEOUT clk cycles is discarded and reported with a one-cycle error pulse.

module seg_deshift_rx #(
   parameter int DIGITS  = 4,
   parameter int TIMEOUT = 1023
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DIGITS-1:0]     seg_in,
   input  logic                  shiftclk_in,
   output logic [8*DIGITS-1:0]   seg_bytes,
   output logic [4*DIGITS-1:0]   digit_val,
   output logic [DIGITS-1:0]     digit_ok,
   output logic                  frame_done,
   output logic                  frame_err
);

   // Idle timer limit, held in the same 16-bit width as the timer itself.
   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);
   localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

   // Seven-segment glyph to BCD: returns {legal, value}. The dp bit is not
   // part of the pattern; blank and every non-digit glyph decode as illegal 0.
   function automatic logic [4:0] f_decode(input logic [6:0] pat);
      logic [4:0] res;
      case (pat)
         7'h3F:   res = {1'b1, 4'd0};
         7'h06:   res = {1'b1, 4'd1};
         7'h5B:   res = {1'b1, 4'd2};
         7'h4F:   res = {1'b1, 4'd3};
         7'h66:   res = {1'b1, 4'd4};
         7'h6D:   res = {1'b1, 4'd5};
         7'h7D:   res = {1'b1, 4'd6};
         7'h07:   res = {1'b1, 4'd7};
         7'h7F:   res = {1'b1, 4'd8};
         7'h6F:   res = {1'b1, 4'd9};
         default: res = {1'b0, 4'd0};
      endcase
      return res;
   endfunction

   // Synchroniser stages: the data lanes use the same depth as the shift
   // clock so the sampled bit lines up with the detected rising edge.
   logic [DIGITS-1:0]        r_seg_s1;
   logic [DIGITS-1:0]        r_seg_s2;
   logic                     r_sclk_s1;
   logic                     r_sclk_s2;
   logic                     r_sclk_s3;

   // Frame assembly state.
   logic [DIGITS-1:0][7:0]   r_shreg;
   logic [2:0]               r_bit_cnt;
   logic [15:0]              r_timer;

   // Registered outputs.
   logic [8*DIGITS-1:0]      r_seg_bytes;
   logic [4*DIGITS-1:0]      r_digit_val;
   logic [DIGITS-1:0]        r_digit_ok;
   logic                     r_frame_done;
   logic                     r_frame_err;

   // Combinational helpers.
   logic                     w_rise;
   logic                     w_last_bit;
   logic                     w_timer_hit;
   logic                     w_partial;
   logic [DIGITS-1:0][7:0]   w_shreg_nxt;
   logic [8*DIGITS-1:0]      w_bytes_nxt;
   logic [4*DIGITS-1:0]      w_val_nxt;
   logic [DIGITS-1:0]        w_ok_nxt;

   // Two-flop synchronisers for all inputs plus a third shift-clock flop for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg_s1  <= '0;
         r_seg_s2  <= '0;
         r_sclk_s1 <= 1'b0;
         r_sclk_s2 <= 1'b0;
         r_sclk_s3 <= 1'b0;
      end else begin
         r_seg_s1  <= seg_in;
         r_seg_s2  <= r_seg_s1;
         r_sclk_s1 <= shiftclk_in;
         r_sclk_s2 <= r_sclk_s1;
         r_sclk_s3 <= r_sclk_s2;
      end
   end

   // Edge, end-of-frame and timeout qualifiers; a rise always beats the timeout.
   always_comb begin
      w_rise      = r_sclk_s2 & ~r_sclk_s3;
      w_last_bit  = w_rise & (r_bit_cnt == 3'd7);
      w_partial   = (r_bit_cnt != 3'd0);
      w_timer_hit = ~w_rise & (r_timer == TMO_LAST);
   end

   // Next shift-register contents and decode of the byte that would complete on this rise.
   always_comb begin
      w_shreg_nxt = '0;
      w_bytes_nxt = '0;
      w_val_nxt   = '0;
      w_ok_nxt    = '0;
      for (int j = 0; j < DIGITS; j++) begin
         logic [4:0] dec;
         w_shreg_nxt[j]         = {r_shreg[j][6:0], r_seg_s2[j]};
         w_bytes_nxt[8*j +: 8]  = w_shreg_nxt[j];
         dec                    = f_decode(w_shreg_nxt[j][6:0]);
         w_val_nxt[4*j +: 4]    = dec[3:0];
         w_ok_nxt[j]            = dec[4];
      end
   end

   // Shift each lane on a rise; a stalled partial frame is thrown away on timeout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg   <= '0;
         r_bit_cnt <= 3'd0;
      end else if (w_rise) begin
         r_shreg   <= w_shreg_nxt;
         r_bit_cnt <= r_bit_cnt + 3'd1;
      end else if (w_timer_hit && w_partial) begin
         r_shreg   <= '0;
         r_bit_cnt <= 3'd0;
      end else begin
         r_shreg   <= r_shreg;
         r_bit_cnt <= r_bit_cnt;
      end
   end

   // Idle timer: cleared by any rise, otherwise counts up and saturates at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer <= 16'd0;
      end else if (w_rise) begin
         r_timer <= 16'd0;
      end else if (r_timer != TMO_LIMIT) begin
         r_timer <= r_timer + 16'd1;
      end else begin
         r_timer <= r_timer;
      end
   end

   // Output register: load bytes and decode on the 8th bit, pulse done/err for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg_bytes  <= '0;
         r_digit_val  <= '0;
         r_digit_ok   <= '0;
         r_frame_done <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_frame_done <= w_last_bit;
         r_frame_err  <= w_timer_hit & w_partial;
         if (w_last_bit) begin
            r_seg_bytes <= w_bytes_nxt;
            r_digit_val <= w_val_nxt;
            r_digit_ok  <= w_ok_nxt;
         end else begin
            r_seg_bytes <= r_seg_bytes;
            r_digit_val <= r_digit_val;
            r_digit_ok  <= r_digit_ok;
         end
      end
   end

   assign seg_bytes  = r_seg_bytes;
   assign digit_val  = r_digit_val;
   assign digit_ok   = r_digit_ok;
   assign frame_done = r_frame_done;
   assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_seg_deshift_rx.sv
// Testbench for seg_deshift_rx: directed frames driven on the serial pins,
// expected frame results queued as frames are sent and compared whenever the
// DUT pulses frame_done.

module tb_seg_deshift_rx;

   localparam int DIGITS = 4;
   localparam int TMO    = 1023;

   typedef struct packed {
      logic [31:0] seg;
      logic [15:0] val;
      logic [3:0]  ok;
   } exp_t;

   logic                clk;
   logic                rst_n;
   logic [DIGITS-1:0]   seg_in;
   logic                shiftclk_in;
   logic [8*DIGITS-1:0] seg_bytes;
   logic [4*DIGITS-1:0] digit_val;
   logic [DIGITS-1:0]   digit_ok;
   logic                frame_done;
   logic                frame_err;

   int   checks        = 0;
   int   failures      = 0;
   int   cyc           = 0;
   int   last_rise_cyc = 0;
   int   done_count    = 0;
   int   err_count     = 0;
   exp_t exp_q[$];

   seg_deshift_rx #(.DIGITS(DIGITS), .TIMEOUT(TMO)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .seg_in      (seg_in),
      .shiftclk_in (shiftclk_in),
      .seg_bytes   (seg_bytes),
      .digit_val   (digit_val),
      .digit_ok    (digit_ok),
      .frame_done  (frame_done),
      .frame_err   (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: on every frame_done pop one expected frame and compare.
   always @(posedge clk) begin
      #1;
      if (frame_err === 1'b1) err_count++;
      if (frame_done === 1'b1) begin
         exp_t e;
         done_count++;
         check("latency", 32'(cyc - last_rise_cyc), 32'd3);
         checks++;
         assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL unexpected_frame_done observed=%0d expected=%0d", exp_q.size(), 1);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("seg_bytes", seg_bytes, e.seg);
            check("digit_val", {16'd0, digit_val}, {16'd0, e.val});
            check("digit_ok", {28'd0, digit_ok}, {28'd0, e.ok});
         end
      end
   end

   task automatic send_bit(input logic [DIGITS-1:0] b);
      @(negedge clk);
      seg_in = b;
      repeat (2) @(negedge clk);
      shiftclk_in   = 1'b1;
      last_rise_cyc = cyc;
      repeat (4) @(negedge clk);
      shiftclk_in = 1'b0;
   endtask

   task automatic send_bits(input logic [7:0] l0, input logic [7:0] l1,
                            input logic [7:0] l2, input logic [7:0] l3, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         send_bit({l3[i], l2[i], l1[i], l0[i]});
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int d0;
      int e0;
      rst_n       = 1'b0;
      seg_in      = '0;
      shiftclk_in = 1'b0;
      wait_cycles(3);

      // Reset state
      check("rst_seg_bytes", seg_bytes, 32'h0);
      check("rst_digit_val", {16'd0, digit_val}, 32'h0);
      check("rst_digit_ok", {28'd0, digit_ok}, 32'h0);
      check("rst_done_err", {30'd0, frame_done, frame_err}, 32'h0);
      rst_n = 1'b1;
      wait_cycles(3);

      // Frame: 3F 06 5B CF (dp set on lane 3)
      exp_q.push_back('{32'hCF5B063F, 16'h3210, 4'b1111});
      send_bits(8'h3F, 8'h06, 8'h5B, 8'hCF, 8);
      wait_cycles(6);
      check("frame1_done_count", 32'(done_count), 32'd1);

      // Frame: lane1 blank, lane2 illegal 77, others 8
      exp_q.push_back('{32'h7F77007F, 16'h8008, 4'b1001});
      send_bits(8'h7F, 8'h00, 8'h77, 8'h7F, 8);
      wait_cycles(6);
      check("frame2_done_count", 32'(done_count), 32'd2);
      check("frame2_no_err", 32'(err_count), 32'd0);

      // Five edges then stall: expect one frame_err, bytes held
      send_bits(8'hA5, 8'h5A, 8'hFF, 8'h00, 5);
      e0 = err_count;
      for (int i = 0; i < TMO + 60; i++) begin
         if (err_count != e0) break;
         @(negedge clk);
      end
      wait_cycles(10);
      check("timeout_err_pulses", 32'(err_count - e0), 32'd1);
      check("timeout_bytes_held", seg_bytes, 32'h7F77007F);
      check("timeout_no_done", 32'(done_count), 32'd2);

      // Resync frame after the discarded partial
      exp_q.push_back('{32'h6F6F6F6F, 16'h9999, 4'b1111});
      send_bits(8'h6F, 8'h6F, 8'h6F, 8'h6F, 8);
      wait_cycles(6);
      check("resync_done_count", 32'(done_count), 32'd3);

      // Back-to-back frames
      exp_q.push_back('{32'h6D6D6D6D, 16'h5555, 4'b1111});
      exp_q.push_back('{32'h07070707, 16'h7777, 4'b1111});
      send_bits(8'h6D, 8'h6D, 8'h6D, 8'h6D, 8);
      send_bits(8'h07, 8'h07, 8'h07, 8'h07, 8);
      wait_cycles(6);
      check("b2b_done_count", 32'(done_count), 32'd5);
      check("b2b_digit_val", {16'd0, digit_val}, 32'h7777);

      // Reset after four edges of a frame
      e0 = err_count;
      send_bits(8'h12, 8'h34, 8'h56, 8'h78, 4);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_seg_bytes", seg_bytes, 32'h0);
      check("midrst_digit_val", {16'd0, digit_val}, 32'h0);
      check("midrst_digit_ok", {28'd0, digit_ok}, 32'h0);
      wait_cycles(4);
      rst_n = 1'b1;
      wait_cycles(3);
      exp_q.push_back('{32'h66666666, 16'h4444, 4'b1111});
      send_bits(8'h66, 8'h66, 8'h66, 8'h66, 8);
      wait_cycles(6);
      check("midrst_done_count", 32'(done_count), 32'd6);
      check("midrst_no_err", 32'(err_count - e0), 32'd0);

      // Long idle with no partial frame: nothing happens
      d0 = done_count;
      e0 = err_count;
      wait_cycles(3 * TMO + 20);
      check("idle_no_err", 32'(err_count - e0), 32'd0);
      check("idle_no_done", 32'(done_count - d0), 32'd0);
      check("idle_seg_bytes", seg_bytes, 32'h66666666);
      check("idle_digit_val", {16'd0, digit_val}, 32'h4444);
      check("idle_digit_ok", {28'd0, digit_ok}, 32'h0000000F);

      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_deshift_rx.md
Name: seg_deshift_rx

Overview:
- Receive-side counterpart of the counter's serial display driver.
- Takes the per-digit serial segment lines plus the shift clock emitted on the uio pins and oversamples them with the system clock.
- Reassembles one 8-bit segment byte per digit and decodes each byte back to a BCD value with a legality flag.
- Used as an on-chip loopback checker and as the display-side model in system benches.

Parameters:
- DIGITS, 4, number of serial segment lanes / digits.
- TIMEOUT, 1023, clk cycles without a shift-clock rising edge after which a partial frame is discarded (range 16..65535).

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- seg_in  input  DIGITS  serial segment data, one lane per digit; asynchronous to clk.
- shiftclk_in  input  1  serial shift clock; data is valid at its rising edge; asynchronous to clk.
- seg_bytes  output  8*DIGITS  last complete segment byte per digit; digit j at [8j+7:8j].
- digit_val  output  4*DIGITS  decoded BCD per digit; digit j at [4j+3:4j].
- digit_ok  output  DIGITS  1 = digit j's byte is a legal glyph 0-9.
- frame_done  output  1  one-cycle pulse when a complete 8-bit frame has been latched.
- frame_err  output  1  one-cycle pulse when a partial frame is dropped by timeout.

Behaviour:
- Reset (rst_n=0, async): all sync flops, shift registers and bit counter cleared. Idle timer = 0. seg_bytes=0, digit_val=0, digit_ok=0, frame_done=0, frame_err=0.
- Synchronisation: shiftclk_in and every seg_in lane pass through a 2-flop synchroniser of equal depth. A third flop on the shift clock gives edge detection. rise = sync2 & ~sync3.
- Input timing: shiftclk_in high and low phases each ≥3 clk cycles. seg_in must be stable from 1 clk before to 3 clk after each rising edge. Narrower pulses are out of spec; no behaviour is guaranteed.
- Frame format: 8 bits per lane, MSB first. Bit order is dp, g, f, e, d, c, b, a, so the assembled byte is {dp,g,f,e,d,c,b,a}. Active-high segments. All lanes shift in lockstep.
- On each rise:
  - Each lane's shift register shifts left, taking the synchronised seg_in bit.
  - bit_cnt (3 bits) increments and the idle timer clears.
- On the rise where bit_cnt==7 (8th bit):
  - bit_cnt wraps to 0.
  - On the next clk edge, seg_bytes for all lanes loads the assembled bytes.
  - digit_val and digit_ok update in the same cycle.
  - frame_done pulses for exactly that cycle.
- Latency: outputs update and frame_done is high 3 clk cycles after the 8th shiftclk_in rising edge at the pin.
- Outputs hold between frames.
- Decode: the dp bit is ignored. The 7-bit {g..a} pattern maps as follows:
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9.
  - Any other pattern gives digit_val=0 and digit_ok=0.
  - 00 (blank) is illegal.
- Idle timeout:
  - The timer counts clk cycles with no rise, saturating at TIMEOUT.
  - If the timer reaches TIMEOUT while bit_cnt≠0: bit_cnt clears, partial data is discarded, and frame_err pulses one cycle. seg_bytes are unchanged.
  - If bit_cnt==0 when the timer reaches TIMEOUT, no error is raised.
  - Subsequent frames resynchronise from bit 0.
- Simultaneous events: a rise in the same cycle the timer would reach TIMEOUT counts as activity. Shift in, clear the timer, raise no error.
- Reset mid-frame: all partial data is lost and outputs return to their reset values immediately. The next rise after release is bit 0.
- Consecutive frames need no gap. The first rise after a completed frame is bit 0 of the next frame.

Test Plan:
- Reset then one frame with lanes 0..3 = 3F, 06, 5B, CF (dp set) → seg_bytes=CF5B063F, digit_val=3210, digit_ok=1111, frame_done exactly one pulse 3 clk after the 8th edge.
- Frame with lane 1 = 00 and lane 2 = 77 (others 7F) → digit_ok=1001, digit_val=8008, frame_done pulses, frame_err=0.
- 5 shift edges then idle for TIMEOUT cycles → frame_err one pulse, seg_bytes unchanged. A following full frame of 6F on all lanes gives digit_val=9999 and digit_ok=1111.
- Two back-to-back frames (6D then 07 on all lanes, no gap) → two frame_done pulses; final digit_val=7777.
- Assert rst_n low after 4 edges of a frame, release, send a full frame 66 on all lanes → outputs 0 during reset, then digit_val=4444 with no frame_err.
- Idle with bit_cnt==0 for 3×TIMEOUT cycles → no frame_err, outputs stable.
